regfile_exec: RTL and testbench

- Execution sequencer that sits directly in front of regfile1 and is its only master.
- Accepts one calculator command per handshake and drives rsel to read up to two operands from the register file's q output.
- Computes a 16-bit result and writes it back through d/wsel/we.
- Maintains zero/carry flags for the calculator front end.

---
 rtl/regfile_exec_if.sv | 36 +++
 rtl/regfile_exec.sv | 168 ++++++++++++++++
 tb/tb_regfile_exec.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_exec_if.sv
// Command handshake plus regfile1 read/write bus for regfile_exec.
// slave is the sequencer side; master is the command source / regfile side.
interface regfile_exec_if #(
  parameter int W = 16
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [3:0]   cmd_op;
  logic [1:0]   cmd_dst;
  logic [1:0]   cmd_srca;
  logic [1:0]   cmd_srcb;
  logic [W-1:0] cmd_imm;
  logic [W-1:0] q;
  logic [1:0]   rsel;
  logic [1:0]   wsel;
  logic [W-1:0] d;
  logic         we;
  logic         done;
  logic         err;
  logic         flag_z;
  logic         flag_c;

  modport slave (
    input  cmd_valid, cmd_op, cmd_dst,
    input  cmd_srca, cmd_srcb, cmd_imm, q,
    output cmd_ready, rsel, wsel, d, we,
    output done, err, flag_z, flag_c
  );

  modport master (
    output cmd_valid, cmd_op, cmd_dst,
    output cmd_srca, cmd_srcb, cmd_imm, q,
    input  cmd_ready, rsel, wsel, d, we,
    input  done, err, flag_z, flag_c
  );
endinterface

// File: rtl/regfile_exec.sv
// Execution sequencer in front of regfile1: reads operands,
// computes a result and writes it back, tracking zero/carry flags.
module regfile_exec #(
  parameter int W       = 16,
  parameter int MUL_CYC = 16
) (
  input logic           ck,
  input logic           res,
  regfile_exec_if.slave bus
);
  localparam int CW = (MUL_CYC > 1) ? $clog2(MUL_CYC) : 1;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_MUL = 4'd7;
  localparam logic [3:0] OP_LDI = 4'd8;
  localparam logic [3:0] OP_MOV = 4'd9;

  typedef enum logic [2:0] {
    IDLE, RD_A, RD_B, EXEC, WB
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     op_q;
  logic [1:0]     dst_q, srcb_q;
  logic [1:0]     rsel_q, wsel_q;
  logic [W-1:0]   a_q, b_q, d_q;
  logic [2*W-1:0] acc_q, acc_step;
  logic [CW-1:0]  cnt_q;
  logic           z_q, c_q;
  logic           legal, is_mul, last;
  logic [W-1:0]   res_w;
  logic           res_c;
  logic [W:0]     sum;

  assign legal  = op_q <= OP_MOV;
  assign is_mul = op_q == OP_MUL;
  assign last   = !is_mul || cnt_q == '0;

  // MSB-first shift-add: cnt_q indexes the B bit for this step
  assign acc_step = {acc_q[2*W-2:0], 1'b0}
                  + (b_q[cnt_q] ? {{W{1'b0}}, a_q} : '0);

  always_comb begin
    sum   = '0;
    res_w = '0;
    res_c = 1'b0;
    case (op_q)
      OP_ADD: begin
        sum   = {1'b0, a_q} + {1'b0, b_q};
        res_w = sum[W-1:0];
        res_c = sum[W];
      end
      OP_SUB: begin
        sum   = {1'b0, a_q} - {1'b0, b_q};
        res_w = sum[W-1:0];
        res_c = sum[W];
      end
      OP_AND: res_w = a_q & b_q;
      OP_OR:  res_w = a_q | b_q;
      OP_XOR: res_w = a_q ^ b_q;
      OP_SHL: begin
        res_w = {a_q[W-2:0], 1'b0};
        res_c = a_q[W-1];
      end
      OP_SHR: begin
        res_w = {1'b0, a_q[W-1:1]};
        res_c = a_q[0];
      end
      OP_MUL: begin
        res_w = acc_step[W-1:0];
        res_c = |acc_step[2*W-1:W];
      end
      OP_MOV: res_w = a_q;
      default: ;
    endcase
  end

  always_ff @(posedge ck or negedge res) begin
    if (!res) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.cmd_valid)
        state_d = (bus.cmd_op == OP_LDI) ? WB : RD_A;
      RD_A:    state_d = RD_B;
      RD_B:    state_d = EXEC;
      EXEC:    if (last) state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ck or negedge res) begin
    if (!res) begin
      op_q   <= '0;
      dst_q  <= '0;
      srcb_q <= '0;
      rsel_q <= '0;
      wsel_q <= '0;
      a_q    <= '0;
      b_q    <= '0;
      d_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      z_q    <= 1'b0;
      c_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.cmd_valid) begin
          op_q   <= bus.cmd_op;
          dst_q  <= bus.cmd_dst;
          srcb_q <= bus.cmd_srcb;
          if (bus.cmd_op == OP_LDI) begin
            wsel_q <= bus.cmd_dst;
            d_q    <= bus.cmd_imm;
            z_q    <= bus.cmd_imm == '0;
            c_q    <= 1'b0;
          end else begin
            rsel_q <= bus.cmd_srca;
          end
        end
        RD_A: begin
          a_q    <= bus.q;
          rsel_q <= srcb_q;
        end
        RD_B: begin
          b_q   <= bus.q;
          acc_q <= '0;
          cnt_q <= CW'(MUL_CYC - 1);
        end
        EXEC: begin
          if (is_mul) begin
            acc_q <= acc_step;
            cnt_q <= cnt_q - 1'b1;
          end
          if (last && legal) begin
            wsel_q <= dst_q;
            d_q    <= res_w;
            z_q    <= res_w == '0;
            c_q    <= res_c;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.cmd_ready = state_q == IDLE;
    bus.we        = state_q == WB && legal;
    bus.done      = state_q == WB;
    bus.err       = state_q == WB && !legal;
    bus.rsel      = rsel_q;
    bus.wsel      = wsel_q;
    bus.d         = d_q;
    bus.flag_z    = z_q;
    bus.flag_c    = c_q;
  end
endmodule

// File: tb/tb_regfile_exec.sv
// Bench for regfile_exec: regfile1 model on the bus plus a
// behavioural reference of the calculator semantics.
module tb_regfile_exec;
  localparam int W       = 16;
  localparam int MUL_CYC = 16;

  logic ck  = 1'b0;
  logic res = 1'b1;

  regfile_exec_if #(.W(W)) bus();

  regfile_exec #(.W(W), .MUL_CYC(MUL_CYC)) dut (
    .ck  (ck),
    .res (res),
    .bus (bus)
  );

  always #5 ck = ~ck;

  logic [W-1:0] rf [4] = '{default: '0};
  int writes = 0;

  assign bus.q = rf[bus.rsel];

  always @(posedge ck) begin
    if (bus.we) begin
      rf[bus.wsel] <= bus.d;
      writes       <= writes + 1;
    end
  end

  int checks = 0;
  int errors = 0;
  logic [W-1:0] m_rf [4] = '{default: '0};
  logic m_z = 1'b0;
  logic m_c = 1'b0;

  function automatic void model(
    input  logic [3:0]   op,
    input  logic [W-1:0] a, b, imm,
    output logic [W-1:0] r,
    output logic         c,
    output logic         ok
  );
    int unsigned s;
    logic [31:0] p;
    ok = 1'b1;
    c  = 1'b0;
    r  = '0;
    case (op)
      4'd0: begin
        s = int'(a) + int'(b);
        r = s[15:0];
        c = s > 32'd65535;
      end
      4'd1: begin r = a - b; c = a < b; end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: begin r = a << 1; c = a[15]; end
      4'd6: begin r = a >> 1; c = a[0]; end
      4'd7: begin
        p = 32'(a) * 32'(b);
        r = p[15:0];
        c = p[31:16] != 16'd0;
      end
      4'd8: r = imm;
      4'd9: r = a;
      default: ok = 1'b0;
    endcase
  endfunction

  task automatic drive_rand();
    bus.cmd_op   = 4'($urandom);
    bus.cmd_dst  = 2'($urandom);
    bus.cmd_srca = 2'($urandom);
    bus.cmd_srcb = 2'($urandom);
    bus.cmd_imm  = W'($urandom);
  endtask

  task automatic check_state(input string name);
    bit bad = 0;
    for (int i = 0; i < 4; i++)
      if (rf[i] !== m_rf[i]) bad = 1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s regs: got %h %h %h %h want %h %h %h %h",
               name, rf[0], rf[1], rf[2], rf[3],
               m_rf[0], m_rf[1], m_rf[2], m_rf[3]);
    end
    checks++;
    if ({bus.flag_z, bus.flag_c} !== {m_z, m_c}) begin
      errors++;
      $display("FAIL %s flags: got z%b c%b want z%b c%b",
               name, bus.flag_z, bus.flag_c, m_z, m_c);
    end
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s idle: got ready %b want 1",
               name, bus.cmd_ready);
    end
  endtask

  // Called at a negedge with the sequencer idle; returns at a negedge.
  task automatic run_cmd(
    input logic [3:0]   op,
    input logic [1:0]   dst, sa, sb,
    input logic [W-1:0] imm,
    input bit           hold,
    input string        name
  );
    logic [W-1:0] er;
    logic ec, eok;
    int lat, wecnt;
    bit seen;
    model(op, m_rf[sa], m_rf[sb], imm, er, ec, eok);
    lat = (op == 4'd8) ? 1 : (op == 4'd7) ? 3 + MUL_CYC : 4;
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready: got %b want 1", name, bus.cmd_ready);
    end
    bus.cmd_op    = op;
    bus.cmd_dst   = dst;
    bus.cmd_srca  = sa;
    bus.cmd_srcb  = sb;
    bus.cmd_imm   = imm;
    bus.cmd_valid = 1'b1;
    @(posedge ck);
    seen  = 0;
    wecnt = 0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge ck);
      if (op != 4'd8 && (k == 1 || k == 2)) begin
        checks++;
        if (bus.rsel !== (k == 1 ? sa : sb)) begin
          errors++;
          $display("FAIL %s rsel%0d: got %0d want %0d", name, k,
                   bus.rsel, (k == 1 ? sa : sb));
        end
      end
      if (bus.we === 1'b1) wecnt++;
      if (bus.done === 1'b1) begin
        seen = 1;
        checks++;
        if (k != lat) begin
          errors++;
          $display("FAIL %s latency: got %0d want %0d", name, k, lat);
        end
        checks++;
        if (bus.err !== !eok) begin
          errors++;
          $display("FAIL %s err: got %b want %b", name, bus.err, !eok);
        end
        if (eok) begin
          checks++;
          if (bus.wsel !== dst || bus.d !== er) begin
            errors++;
            $display("FAIL %s wb: got r%0d=%h want r%0d=%h",
                     name, bus.wsel, bus.d, dst, er);
          end
        end
      end
      if (hold) drive_rand();
      else bus.cmd_valid = 1'b0;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s timeout: got no done want done", name);
    end
    checks++;
    if (wecnt != (eok ? 1 : 0)) begin
      errors++;
      $display("FAIL %s we count: got %0d want %0d",
               name, wecnt, (eok ? 1 : 0));
    end
    if (eok) begin
      m_rf[dst] = er;
      m_z = er == '0;
      m_c = ec;
    end
    @(negedge ck);
    check_state(name);
  endtask

  task automatic test_reset();
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 4'd8;
    bus.cmd_dst   = 2'd0;
    bus.cmd_srca  = 2'd0;
    bus.cmd_srcb  = 2'd0;
    bus.cmd_imm   = 16'h4c55;
    repeat (3) begin
      @(negedge ck);
      checks++;
      if (bus.cmd_ready !== 1'b1 || bus.we !== 1'b0 ||
          bus.done !== 1'b0 || bus.flag_z !== 1'b0 ||
          bus.flag_c !== 1'b0 || bus.rsel !== 2'd0) begin
        errors++;
        $display("FAIL reset outs: got rdy%b we%b dn%b z%b c%b rs%0d want 1 0 0 0 0 0",
                 bus.cmd_ready, bus.we, bus.done,
                 bus.flag_z, bus.flag_c, bus.rsel);
      end
    end
    checks++;
    if (writes != 0) begin
      errors++;
      $display("FAIL reset writes: got %0d want 0", writes);
    end
    res = 1'b1;
    @(negedge ck);
    checks++;
    if (bus.done !== 1'b1 || bus.cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset release: got done %b ready %b want 1 0",
               bus.done, bus.cmd_ready);
    end
    bus.cmd_valid = 1'b0;
    m_rf[0] = 16'h4c55;
    @(negedge ck);
    check_state("reset ldi");
  endtask

  task automatic test_add();
    run_cmd(4'd8, 2'd0, 2'd0, 2'd0, 16'h4c55, 0, "ldi r0");
    run_cmd(4'd8, 2'd1, 2'd0, 2'd0, 16'h0001, 0, "ldi r1");
    run_cmd(4'd0, 2'd2, 2'd0, 2'd1, 16'h0000, 0, "add");
    checks++;
    if (rf[2] !== 16'h4c56 || bus.flag_z !== 1'b0 ||
        bus.flag_c !== 1'b0) begin
      errors++;
      $display("FAIL add value: got %h z%b c%b want 4c56 z0 c0",
               rf[2], bus.flag_z, bus.flag_c);
    end
  endtask

  task automatic test_overflow();
    run_cmd(4'd8, 2'd0, 2'd0, 2'd0, 16'hffff, 0, "ldi ffff");
    run_cmd(4'd0, 2'd0, 2'd0, 2'd1, 16'h0000, 0, "add wrap");
    checks++;
    if (rf[0] !== 16'h0000 || bus.flag_z !== 1'b1 ||
        bus.flag_c !== 1'b1) begin
      errors++;
      $display("FAIL add wrap value: got %h z%b c%b want 0000 z1 c1",
               rf[0], bus.flag_z, bus.flag_c);
    end
    run_cmd(4'd1, 2'd3, 2'd1, 2'd0, 16'h0000, 0, "sub r1-r0");
    run_cmd(4'd1, 2'd3, 2'd0, 2'd1, 16'h0000, 0, "sub r0-r1");
    checks++;
    if (rf[3] !== 16'hffff || bus.flag_c !== 1'b1) begin
      errors++;
      $display("FAIL sub borrow: got %h c%b want ffff c1",
               rf[3], bus.flag_c);
    end
  endtask

  task automatic test_mul();
    run_cmd(4'd8, 2'd0, 2'd0, 2'd0, 16'h0100, 0, "ldi 0100");
    run_cmd(4'd8, 2'd1, 2'd0, 2'd0, 16'h0300, 0, "ldi 0300");
    run_cmd(4'd7, 2'd2, 2'd0, 2'd1, 16'h0000, 0, "mul ovf");
    checks++;
    if (rf[2] !== 16'h0000 || bus.flag_z !== 1'b1 ||
        bus.flag_c !== 1'b1) begin
      errors++;
      $display("FAIL mul ovf value: got %h z%b c%b want 0000 z1 c1",
               rf[2], bus.flag_z, bus.flag_c);
    end
    run_cmd(4'd8, 2'd0, 2'd0, 2'd0, 16'h00ff, 0, "ldi 00ff");
    run_cmd(4'd8, 2'd1, 2'd0, 2'd0, 16'h0002, 0, "ldi 0002");
    run_cmd(4'd7, 2'd2, 2'd0, 2'd1, 16'h0000, 0, "mul");
    checks++;
    if (rf[2] !== 16'h01fe || bus.flag_c !== 1'b0) begin
      errors++;
      $display("FAIL mul value: got %h c%b want 01fe c0",
               rf[2], bus.flag_c);
    end
  endtask

  task automatic test_illegal();
    run_cmd(4'd8, 2'd3, 2'd0, 2'd0, 16'hffff, 0, "ldi r3");
    run_cmd(4'd8, 2'd1, 2'd0, 2'd0, 16'h0001, 0, "ldi r1 one");
    run_cmd(4'd0, 2'd2, 2'd3, 2'd1, 16'h0000, 0, "add z c");
    run_cmd(4'd12, 2'd3, 2'd0, 2'd1, 16'h0000, 0, "illegal");
    checks++;
    if (bus.flag_z !== 1'b1 || bus.flag_c !== 1'b1 ||
        rf[3] !== 16'hffff) begin
      errors++;
      $display("FAIL illegal keep: got z%b c%b r3=%h want z1 c1 ffff",
               bus.flag_z, bus.flag_c, rf[3]);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++)
      run_cmd(4'($urandom_range(0, 11)), 2'($urandom),
              2'($urandom), 2'($urandom), W'($urandom),
              1, "b2b");
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset_mid_mul();
    int w0;
    run_cmd(4'd8, 2'd3, 2'd0, 2'd0, 16'h1234, 0, "ldi r3 pre");
    run_cmd(4'd8, 2'd0, 2'd0, 2'd0, 16'h0100, 0, "ldi r0 pre");
    run_cmd(4'd8, 2'd1, 2'd0, 2'd0, 16'h0300, 0, "ldi r1 pre");
    w0 = writes;
    bus.cmd_op    = 4'd7;
    bus.cmd_dst   = 2'd3;
    bus.cmd_srca  = 2'd0;
    bus.cmd_srcb  = 2'd1;
    bus.cmd_valid = 1'b1;
    @(posedge ck);
    @(negedge ck);
    bus.cmd_valid = 1'b0;
    repeat (6) @(negedge ck);
    res = 1'b0;
    #1;
    m_z = 1'b0;
    m_c = 1'b0;
    checks++;
    if (bus.we !== 1'b0 || bus.cmd_ready !== 1'b1 ||
        bus.done !== 1'b0 || bus.flag_z !== 1'b0 ||
        bus.flag_c !== 1'b0) begin
      errors++;
      $display("FAIL mid reset: got we%b rdy%b dn%b z%b c%b want 0 1 0 0 0",
               bus.we, bus.cmd_ready, bus.done,
               bus.flag_z, bus.flag_c);
    end
    @(negedge ck);
    res = 1'b1;
    @(negedge ck);
    checks++;
    if (writes != w0 || rf[3] !== 16'h1234) begin
      errors++;
      $display("FAIL mid reset write: got %0d writes r3=%h want %0d 1234",
               writes - w0, rf[3], 0);
    end
    check_state("after reset");
    run_cmd(4'd8, 2'd3, 2'd0, 2'd0, 16'hbeef, 0, "ldi post");
  endtask

  initial begin
    res           = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_dst   = '0;
    bus.cmd_srca  = '0;
    bus.cmd_srcb  = '0;
    bus.cmd_imm   = '0;
    test_reset();
    test_add();
    test_overflow();
    test_mul();
    test_illegal();
    test_back_to_back();
    test_reset_mid_mul();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
